// File: rtl/jk_pkg.sv
// Shared definitions for the JK excitation driver slice.
// State encodings are exported both as plain localparam constants (used by
// the FSM register itself) and as an enum type for tools and debug views.
// Optional feature macro handled by jk_excite_enc: JK_EXCITE_TOGGLE_EN.
package jk_pkg;

    // Width of the driver state register.
    localparam int STATE_W = 3;

    // Raw state encodings kept as constants so legacy code can compare
    // against them without depending on the enum type.
    localparam logic [STATE_W-1:0] ST_IDLE   = 3'd0;
    localparam logic [STATE_W-1:0] ST_DRIVE  = 3'd1;
    localparam logic [STATE_W-1:0] ST_SETTLE = 3'd2;
    localparam logic [STATE_W-1:0] ST_CHECK  = 3'd3;
    localparam logic [STATE_W-1:0] ST_ERROR  = 3'd4;

    // Enum view of the same encodings.
    typedef enum logic [STATE_W-1:0] {
        JK_IDLE   = ST_IDLE,
        JK_DRIVE  = ST_DRIVE,
        JK_SETTLE = ST_SETTLE,
        JK_CHECK  = ST_CHECK,
        JK_ERROR  = ST_ERROR
    } jk_state_e;

    // Width of a retry counter able to hold 0..max_retry, never below one bit.
    function automatic int retry_cnt_width(input int max_retry);
        int w;
        w = $clog2(max_retry + 1);
        if (w < 1) begin
            w = 1;
        end
        return w;
    endfunction

    // True for states in which the driver owns the JK bank.
    function automatic logic state_is_busy(input logic [STATE_W-1:0] st);
        return (st == ST_DRIVE) || (st == ST_SETTLE) || (st == ST_CHECK);
    endfunction

endpackage

// File: rtl/jk_excite_enc.sv
// Per-bit JK excitation encoder (purely combinational).
// Given the wanted value t and the present flip-flop value q it produces the
// J/K pair that moves each bit from q to t.
// Default build uses set/reset encoding with don't-cares resolved to 0:
//   j = t & ~q, k = ~t & q  (bits already correct get J=K=0, a hold).
// With JK_EXCITE_TOGGLE_EN defined every differing bit is toggled instead:
//   j = k = t ^ q.
module jk_excite_enc
    import jk_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] t,
    input  logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] j,
    output logic [WIDTH-1:0] k
);

    // Select the excitation style at build time.
    always_comb begin
        j = '0;
        k = '0;
`ifdef JK_EXCITE_TOGGLE_EN
        j = t ^ q;
        k = t ^ q;
`else
        j = t & ~q;
        k = ~t & q;
`endif
    end

endmodule

// File: rtl/jk_excite_driver.sv
// JK excitation driver: loads a target word into an external bank of
// enable-gated JK flip-flops, verifies it through the q_fb feedback and
// retries up to MAX_RETRY extra times before raising a sticky error.
// Sequence per attempt: DRIVE (en_out for one cycle) -> SETTLE (bank output
// propagates) -> CHECK (compare). done and err are registered, so done
// appears 3 cycles after the accept edge and each retry adds 3 cycles.
// Optional feature macro: JK_EXCITE_TOGGLE_EN (toggle excitation encoding,
// selected inside jk_excite_enc).
module jk_excite_driver
    import jk_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int MAX_RETRY = 2
) (
    input  logic             clk,
    input  logic             reset_sync,
    input  logic [WIDTH-1:0] target_data,
    input  logic             target_valid,
    output logic             target_ready,
    input  logic [WIDTH-1:0] q_fb,
    output logic [WIDTH-1:0] j_out,
    output logic [WIDTH-1:0] k_out,
    output logic             en_out,
    output logic             done,
    output logic             err,
    input  logic             err_clr
);

    localparam int RETRY_W = retry_cnt_width(MAX_RETRY);
    localparam logic [RETRY_W-1:0] RETRY_LIMIT = RETRY_W'(MAX_RETRY);

    logic [STATE_W-1:0] state;
    logic [STATE_W-1:0] state_nxt;
    logic [WIDTH-1:0]   target_q;
    logic [RETRY_W-1:0] retry_cnt;
    logic [WIDTH-1:0]   enc_j;
    logic [WIDTH-1:0]   enc_k;
    logic               accept;
    logic               match;
    logic               retry_avail;
    logic               drive_active;

    assign accept       = (state == ST_IDLE) && target_valid;
    assign match        = (q_fb == target_q);
    assign retry_avail  = (retry_cnt < RETRY_LIMIT);
    assign drive_active = (state == ST_DRIVE);

    jk_excite_enc #(
        .WIDTH (WIDTH)
    ) u_enc (
        .t (target_q),
        .q (q_fb),
        .j (enc_j),
        .k (enc_k)
    );

    // Next-state decision for the load/settle/check sequence.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (target_valid) begin
                    state_nxt = ST_DRIVE;
                end
            end
            ST_DRIVE: begin
                state_nxt = ST_SETTLE;
            end
            ST_SETTLE: begin
                state_nxt = ST_CHECK;
            end
            ST_CHECK: begin
                if (match) begin
                    state_nxt = ST_IDLE;
                end else if (retry_avail) begin
                    state_nxt = ST_DRIVE;
                end else begin
                    state_nxt = ST_ERROR;
                end
            end
            ST_ERROR: begin
                if (err_clr) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // State register; reset always wins, discarding any in-flight target.
    always_ff @(posedge clk) begin
        if (reset_sync) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Latch the target on accept and count retries; the counter only
    // advances while below its limit, so it cannot wrap.
    always_ff @(posedge clk) begin
        if (reset_sync) begin
            target_q  <= '0;
            retry_cnt <= '0;
        end else if (accept) begin
            target_q  <= target_data;
            retry_cnt <= '0;
        end else if ((state == ST_CHECK) && !match && retry_avail) begin
            retry_cnt <= retry_cnt + 1'b1;
        end
    end

    // Registered completion pulse and sticky error flag.
    always_ff @(posedge clk) begin
        if (reset_sync) begin
            done <= 1'b0;
            err  <= 1'b0;
        end else begin
            done <= (state == ST_CHECK) && match;
            if ((state == ST_ERROR) && err_clr) begin
                err <= 1'b0;
            end else if ((state == ST_CHECK) && !match && !retry_avail) begin
                err <= 1'b1;
            end
        end
    end

    // Bank-facing outputs are live only in DRIVE and forced low elsewhere.
    always_comb begin
        target_ready = (state == ST_IDLE);
        en_out       = drive_active;
        j_out        = '0;
        k_out        = '0;
        if (drive_active) begin
            j_out = enc_j;
            k_out = enc_k;
        end
    end

endmodule
